// File: rtl/bit_reorder_stream_pkg.sv
// -----------------------------------------------------------------------------
// bit_reorder_stream_pkg
//   Shared types and helpers for the streaming bit/lane reorder block.
//   - reorder_mode_t : per-packet reorder mode carried on s_mode.
//   - pkt_state_t    : packet-tracking FSM states.
//   - rev_groups     : reverse the order of g-bit groups within a w-bit word.
//   - rev_in_groups  : reverse the bits inside every g-bit group of a w-bit word.
//   Both helpers work on a fixed-size container (RO_MAX_W bits), touch only the
//   low w bits and return zeros above them. Callers pass constant w/g, so the
//   loops fold down to plain wiring.
// -----------------------------------------------------------------------------
package bit_reorder_stream_pkg;

    typedef enum logic [1:0] {
        RO_PASS        = 2'b00,
        RO_LANE_BITREV = 2'b01,
        RO_LANE_SWAP   = 2'b10,
        RO_FULL_REV    = 2'b11
    } reorder_mode_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } pkt_state_t;

    // Widest word the helpers can handle.
    localparam int RO_MAX_W = 512;

    typedef logic [RO_MAX_W-1:0] ro_vec_t;

    // Output group i takes input group n-1-i (n = w/g groups); bit order
    // inside a group is preserved. g=1 gives a full-word bit reverse.
    function automatic ro_vec_t rev_groups(input ro_vec_t     v,
                                           input int unsigned w,
                                           input int unsigned g);
        ro_vec_t     r;
        int unsigned n;
        r = '0;
        n = w / g;
        for (int unsigned k = 0; k < RO_MAX_W; k++) begin
            if (k < w) begin
                r[k] = v[(n - 1 - (k / g)) * g + (k % g)];
            end
        end
        return r;
    endfunction

    // Every g-bit group stays in place but has its bits mirrored.
    function automatic ro_vec_t rev_in_groups(input ro_vec_t     v,
                                              input int unsigned w,
                                              input int unsigned g);
        ro_vec_t r;
        r = '0;
        for (int unsigned k = 0; k < RO_MAX_W; k++) begin
            if (k < w) begin
                r[k] = v[(k / g) * g + (g - 1 - (k % g))];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_reorder_stream_core.sv
// -----------------------------------------------------------------------------
// bit_reorder_core
//   Purely combinational data/keep permutation.
//   Ports:
//     data_i  [DATA_W]    input beat data
//     keep_i  [DATA_W/8]  input byte enables
//     mode_i              reorder mode for this beat
//     data_o  [DATA_W]    reordered data
//     keep_o  [DATA_W/8]  byte enables permuted to follow the data
// -----------------------------------------------------------------------------
module bit_reorder_core
    import bit_reorder_stream_pkg::*;
#(
    parameter  int DATA_W = 64,
    parameter  int LANE_W = 8,
    localparam int KEEP_W = DATA_W / 8
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [KEEP_W-1:0] keep_i,
    input  reorder_mode_t     mode_i,
    output logic [DATA_W-1:0] data_o,
    output logic [KEEP_W-1:0] keep_o
);

    // One keep bit per byte, so a lane owns LANE_W/8 keep bits.
    localparam int KEEP_GRP = LANE_W / 8;

    ro_vec_t data_ext;
    ro_vec_t keep_ext;
    ro_vec_t data_res;
    ro_vec_t keep_res;

    always_comb begin
        data_ext               = '0;
        data_ext[DATA_W-1:0]   = data_i;
        keep_ext               = '0;
        keep_ext[KEEP_W-1:0]   = keep_i;
        data_res               = data_ext;
        keep_res               = keep_ext;
        case (mode_i)
            RO_PASS: begin
            end
            RO_LANE_BITREV: begin
                data_res = rev_in_groups(data_ext, DATA_W, LANE_W);
            end
            RO_LANE_SWAP: begin
                data_res = rev_groups(data_ext, DATA_W, LANE_W);
                keep_res = rev_groups(keep_ext, KEEP_W, KEEP_GRP);
            end
            RO_FULL_REV: begin
                data_res = rev_groups(data_ext, DATA_W, 1);
                keep_res = rev_groups(keep_ext, KEEP_W, 1);
            end
            default: begin
            end
        endcase
    end

    assign data_o = data_res[DATA_W-1:0];
    assign keep_o = keep_res[KEEP_W-1:0];

    // Container bits above the real word are always zero and go nowhere.
    logic [2*RO_MAX_W-DATA_W-KEEP_W-1:0] unused_hi;
    assign unused_hi = {data_res[RO_MAX_W-1:DATA_W], keep_res[RO_MAX_W-1:KEEP_W]};

endmodule

// File: rtl/bit_reorder_stream.sv
// -----------------------------------------------------------------------------
// bit_reorder_stream
//   Two-stage valid/ready pipeline that reorders each beat (pass, lane bit
//   reverse, lane swap, full-word reverse). The mode is sampled on the first
//   beat of a packet and held for the rest of it. Keep follows the data.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     s_valid/s_ready     input handshake (s_ready is combinational)
//     s_data/s_keep       input beat and byte enables
//     s_last/s_mode       end-of-packet marker, mode for a packet's first beat
//     m_valid/m_ready     output handshake
//     m_data/m_keep       reordered beat and permuted byte enables
//     m_last              end-of-packet marker travelling with the beat
//     stat_clr            synchronous clear of the statistics counters
//     pkt_cnt/beat_cnt    packets / beats delivered at the output
// -----------------------------------------------------------------------------
module bit_reorder_stream
    import bit_reorder_stream_pkg::*;
#(
    parameter  int DATA_W = 64,
    parameter  int LANE_W = 8,
    parameter  int CNT_W  = 32,
    localparam int KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [KEEP_W-1:0] s_keep,
    input  logic              s_last,
    input  logic [1:0]        s_mode,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [KEEP_W-1:0] m_keep,
    output logic              m_last,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  beat_cnt
);

    generate
        if (DATA_W % LANE_W != 0) begin : g_chk_lane_div
            $fatal(1, "bit_reorder_stream: DATA_W must be a multiple of LANE_W");
        end
        if (LANE_W % 8 != 0) begin : g_chk_lane_byte
            $fatal(1, "bit_reorder_stream: LANE_W must be a multiple of 8");
        end
        if (DATA_W > RO_MAX_W) begin : g_chk_max_w
            $fatal(1, "bit_reorder_stream: DATA_W exceeds RO_MAX_W");
        end
    endgenerate

    // Pipeline state
    logic              vld_p1_q;
    logic [DATA_W-1:0] data_p1_q;
    logic [KEEP_W-1:0] keep_p1_q;
    logic              last_p1_q;
    reorder_mode_t     mode_p1_q;

    logic              vld_p2_q;
    logic [DATA_W-1:0] data_p2_q;
    logic [KEEP_W-1:0] keep_p2_q;
    logic              last_p2_q;

    logic              adv1;
    logic              adv2;
    logic              s_fire;
    logic              m_fire;

    // Handshake: a stage may load when it is empty or its content moves on.
    assign adv2    = !vld_p2_q || m_ready;
    assign adv1    = !vld_p1_q || adv2;
    // Held low while reset is asserted so nothing is accepted into a stage
    // that is being flushed.
    assign s_ready = rst_n && adv1;
    assign s_fire  = s_valid && s_ready;
    assign m_fire  = vld_p2_q && m_ready;

    // Packet mode FSM
    pkt_state_t    state_q;
    pkt_state_t    state_d;
    reorder_mode_t mode_q;
    reorder_mode_t mode_d;
    reorder_mode_t eff_mode;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        eff_mode = mode_q;
        // First beat of a packet uses s_mode directly, so it is reordered
        // in the same mode that gets latched for the remaining beats.
        if (state_q == ST_IDLE) begin
            eff_mode = reorder_mode_t'(s_mode);
        end
        if (s_fire) begin
            if (state_q == ST_IDLE) begin
                mode_d  = reorder_mode_t'(s_mode);
                state_d = s_last ? ST_IDLE : ST_IN_PKT;
            end else if (s_last) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= RO_PASS;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // ---- stage 1: register accepted beat with its effective mode ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            data_p1_q <= '0;
            keep_p1_q <= '0;
            last_p1_q <= 1'b0;
            mode_p1_q <= RO_PASS;
        end else if (adv1) begin
            vld_p1_q <= s_fire;
            if (s_fire) begin
                data_p1_q <= s_data;
                keep_p1_q <= s_keep;
                last_p1_q <= s_last;
                mode_p1_q <= eff_mode;
            end
        end
    end

    // ---- stage 1 -> stage 2: combinational reorder ----
    logic [DATA_W-1:0] ro_data;
    logic [KEEP_W-1:0] ro_keep;

    bit_reorder_core #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_core (
        .data_i (data_p1_q),
        .keep_i (keep_p1_q),
        .mode_i (mode_p1_q),
        .data_o (ro_data),
        .keep_o (ro_keep)
    );

    // ---- stage 2: register reordered beat (output register) ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            keep_p2_q <= '0;
            last_p2_q <= 1'b0;
        end else if (adv2) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                data_p2_q <= ro_data;
                keep_p2_q <= ro_keep;
                last_p2_q <= last_p1_q;
            end
        end
    end

    assign m_valid = vld_p2_q;
    assign m_data  = data_p2_q;
    assign m_keep  = keep_p2_q;
    assign m_last  = last_p2_q;

    // Statistics counters
    logic [CNT_W-1:0] pkt_cnt_q;
    logic [CNT_W-1:0] pkt_cnt_d;
    logic [CNT_W-1:0] beat_cnt_q;
    logic [CNT_W-1:0] beat_cnt_d;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        beat_cnt_d = beat_cnt_q;
        // Clear takes priority over a coincident increment.
        if (stat_clr) begin
            pkt_cnt_d  = '0;
            beat_cnt_d = '0;
        end else if (m_fire) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (last_p2_q) begin
                pkt_cnt_d = pkt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_bit_reorder_stream.sv
module tb_bit_reorder_stream;

    localparam int DATA_W = 64;
    localparam int LANE_W = 8;
    localparam int CNT_W  = 32;
    localparam int KEEP_W = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [KEEP_W-1:0] s_keep;
    logic              s_last;
    logic [1:0]        s_mode;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [KEEP_W-1:0] m_keep;
    logic              m_last;
    logic              stat_clr;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [CNT_W-1:0]  beat_cnt;

    always #5 clk = ~clk;

    bit_reorder_stream #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_keep   (s_keep),
        .s_last   (s_last),
        .s_mode   (s_mode),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_keep   (m_keep),
        .m_last   (m_last),
        .stat_clr (stat_clr),
        .pkt_cnt  (pkt_cnt),
        .beat_cnt (beat_cnt)
    );

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    bit          mdl_idle = 1'b1;
    logic [1:0]  mdl_mode = 2'b00;
    logic [31:0] mdl_beats = '0;
    logic [31:0] mdl_pkts  = '0;
    beat_t       inflight[$];
    beat_t       exp_q[$];
    beat_t       obs_q[$];

    // ---------------- reference reorder, from the plain rules ----------------
    function automatic logic [63:0] rev_word(input logic [63:0] d);
        logic [63:0] r;
        for (int k = 0; k < 64; k++) r[63-k] = d[k];
        return r;
    endfunction

    function automatic logic [63:0] swap_lanes(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = d[(7-i)*8 +: 8];
        return r;
    endfunction

    function automatic logic [7:0] rev_keep(input logic [7:0] k);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = k[i];
        return r;
    endfunction

    function automatic beat_t ref_beat(input logic [63:0] d, input logic [7:0] k,
                                       input logic l, input logic [1:0] md);
        beat_t b;
        b.l = l;
        case (md)
            2'b00:   begin b.d = d;                       b.k = k;           end
            // mirroring the whole word then putting lanes back in place
            // leaves each lane bit-reversed where it was
            2'b01:   begin b.d = swap_lanes(rev_word(d)); b.k = k;           end
            2'b10:   begin b.d = swap_lanes(d);           b.k = rev_keep(k); end
            default: begin b.d = rev_word(d);             b.k = rev_keep(k); end
        endcase
        return b;
    endfunction

    // One clock: observe handshakes at the falling edge, update the model,
    // then return 1 time unit after the rising edge.
    task automatic tick(output bit acc);
        logic [1:0] eff;
        @(negedge clk);
        acc = 1'b0;
        if (!rst_n) begin
            inflight.delete();
            mdl_idle  = 1'b1;
            mdl_mode  = 2'b00;
            mdl_beats = '0;
            mdl_pkts  = '0;
        end else begin
            if (m_valid && m_ready) begin
                if (inflight.size() == 0) exp_q.push_back('x);
                else                      exp_q.push_back(inflight.pop_front());
                obs_q.push_back('{d: m_data, k: m_keep, l: m_last});
            end
            if (stat_clr) begin
                mdl_beats = '0;
                mdl_pkts  = '0;
            end else if (m_valid && m_ready) begin
                mdl_beats = mdl_beats + 1;
                if (m_last) mdl_pkts = mdl_pkts + 1;
            end
            if (s_valid && s_ready) begin
                acc = 1'b1;
                eff = mdl_idle ? s_mode : mdl_mode;
                if (mdl_idle) mdl_mode = s_mode;
                mdl_idle = s_last;
                inflight.push_back(ref_beat(s_data, s_keep, s_last, eff));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input logic [1:0] md, output bit ok);
        bit acc;
        s_valid = 1'b1; s_data = d; s_keep = k; s_last = l; s_mode = md;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            tick(acc);
            ok = acc;
        end
        s_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        bit acc;
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int n = 0; n < 100 && inflight.size() != 0; n++) tick(acc);
        ok = (inflight.size() == 0);
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit acc;
        rst_n = 1'b0;
        tick(acc);
        tick(acc);
        tests_run++; if (s_ready !== 1'b0)  begin tests_failed++; $display("FAIL rst_s_ready got %b required 0", s_ready); end
        tests_run++; if (m_valid !== 1'b0)  begin tests_failed++; $display("FAIL rst_m_valid got %b required 0", m_valid); end
        tests_run++; if (m_data !== 64'h0)  begin tests_failed++; $display("FAIL rst_m_data got %h required 0", m_data); end
        tests_run++; if (m_keep !== 8'h0 || m_last !== 1'b0) begin tests_failed++; $display("FAIL rst_keep_last got %h/%b required 0/0", m_keep, m_last); end
        tests_run++; if (pkt_cnt !== 32'h0 || beat_cnt !== 32'h0) begin tests_failed++; $display("FAIL rst_counters got %0d/%0d required 0/0", pkt_cnt, beat_cnt); end
        rst_n = 1'b1;
        #1;
        tests_run++; if (s_ready !== 1'b1)  begin tests_failed++; $display("FAIL rst_release_s_ready got %b required 1", s_ready); end
    endtask

    task automatic test_lane_bitrev();
        bit acc;
        clear_queues();
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = 64'h0102_0408_1020_4080; s_keep = 8'hFF; s_last = 1'b1; s_mode = 2'b01;
        tick(acc);
        s_valid = 1'b0;
        tests_run++; if (acc !== 1'b1) begin tests_failed++; $display("FAIL bitrev_accept got %b required 1", acc); end
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL bitrev_lat1 m_valid got %b required 0", m_valid); end
        tick(acc);
        tests_run++; if (m_valid !== 1'b1) begin tests_failed++; $display("FAIL bitrev_lat2 m_valid got %b required 1", m_valid); end
        tests_run++; if (m_data !== 64'h8040_2010_0804_0201 || m_keep !== 8'hFF) begin tests_failed++; $display("FAIL bitrev_data got %h/%h required 8040201008040201/ff", m_data, m_keep); end
        tick(acc);
        tests_run++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin tests_failed++; $display("FAIL bitrev_model got %0d beats required 1 matching model", obs_q.size()); end
    endtask

    task automatic test_lane_swap();
        bit ok;
        clear_queues();
        send_beat(64'h0011_2233_4455_6677, 8'h0F, 1'b1, 2'b10, ok);
        drain(ok);
        tests_run++;
        if (!ok || obs_q.size() != 1) begin tests_failed++; $display("FAIL swap_count got %0d beats required 1", obs_q.size()); end
        else if (obs_q[0].d !== 64'h7766_5544_3322_1100 || obs_q[0].k !== 8'hF0) begin
            tests_failed++; $display("FAIL swap_data got %h/%h required 7766554433221100/f0", obs_q[0].d, obs_q[0].k);
        end
    endtask

    task automatic test_full_rev();
        bit ok;
        clear_queues();
        send_beat(64'h1, 8'h01, 1'b1, 2'b11, ok);
        drain(ok);
        tests_run++;
        if (!ok || obs_q.size() != 1) begin tests_failed++; $display("FAIL fullrev_count got %0d beats required 1", obs_q.size()); end
        else if (obs_q[0].d !== 64'h8000_0000_0000_0000 || obs_q[0].k !== 8'h80) begin
            tests_failed++; $display("FAIL fullrev_data got %h/%h required 8000000000000000/80", obs_q[0].d, obs_q[0].k);
        end
    endtask

    task automatic test_mode_lock();
        bit acc, ok;
        clear_queues();
        stat_clr = 1'b1; tick(acc); stat_clr = 1'b0;
        send_beat(64'h0011_2233_4455_6677, 8'hFF, 1'b0, 2'b10, ok);
        send_beat(64'h0011_2233_4455_6677, 8'hFF, 1'b0, 2'b00, ok);
        send_beat(64'h0011_2233_4455_6677, 8'hFF, 1'b1, 2'b00, ok);
        send_beat(64'hDEAD_BEEF_0123_4567, 8'h3C, 1'b1, 2'b00, ok);
        drain(ok);
        tests_run++;
        if (!ok || obs_q.size() != 4) begin tests_failed++; $display("FAIL lock_count got %0d beats required 4", obs_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (obs_q[i].d !== 64'h7766_5544_3322_1100) begin tests_failed++; $display("FAIL lock_beat%0d got %h required 7766554433221100", i, obs_q[i].d); end
            end
            tests_run++;
            if (obs_q[3].d !== 64'hDEAD_BEEF_0123_4567 || obs_q[3].k !== 8'h3C) begin tests_failed++; $display("FAIL lock_next_pkt got %h/%h required deadbeef01234567/3c", obs_q[3].d, obs_q[3].k); end
        end
        tests_run++; if (pkt_cnt !== 32'd2)  begin tests_failed++; $display("FAIL lock_pkt_cnt got %0d required 2", pkt_cnt); end
        tests_run++; if (beat_cnt !== 32'd4) begin tests_failed++; $display("FAIL lock_beat_cnt got %0d required 4", beat_cnt); end
    endtask

    task automatic test_backpressure();
        bit          acc, ok, seen, held_bad;
        logic [63:0] beats[6];
        logic [63:0] held;
        int          j;
        clear_queues();
        for (int i = 0; i < 6; i++) beats[i] = {$urandom, $urandom};
        j = 0; seen = 1'b0; held_bad = 1'b0; held = '0;
        m_ready = 1'b0;
        s_valid = 1'b1; s_keep = 8'hA5; s_mode = 2'b10;
        for (int c = 0; c < 5; c++) begin
            s_data = beats[j]; s_last = (j == 5);
            tick(acc);
            if (acc) j++;
            if (m_valid) begin
                if (!seen) begin held = m_data; seen = 1'b1; end
                else if (m_data !== held) held_bad = 1'b1;
            end
        end
        tests_run++; if (j != 2) begin tests_failed++; $display("FAIL bp_accepted got %0d required 2", j); end
        tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_s_ready got %b required 0", s_ready); end
        tests_run++; if (!seen || held_bad) begin tests_failed++; $display("FAIL bp_hold got seen=%b changed=%b required 1/0", seen, held_bad); end
        m_ready = 1'b1;
        for (int c = 0; c < 50 && j < 6; c++) begin
            s_data = beats[j]; s_last = (j == 5);
            tick(acc);
            if (acc) j++;
        end
        drain(ok);
        tests_run++;
        if (!ok || obs_q.size() != 6) begin tests_failed++; $display("FAIL bp_count got %0d beats required 6", obs_q.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL bp_beat%0d got %h required %h", i, obs_q[i].d, exp_q[i].d); end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        bit acc, ok;
        clear_queues();
        send_beat(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 2'b11, ok);
        s_valid = 1'b1; s_data = 64'h1111_2222_3333_4444; s_last = 1'b0; s_mode = 2'b11;
        rst_n = 1'b0;
        tick(acc);
        rst_n = 1'b1; s_valid = 1'b0;
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_m_valid got %b required 0", m_valid); end
        tests_run++; if (pkt_cnt !== 32'h0 || beat_cnt !== 32'h0) begin tests_failed++; $display("FAIL midrst_counters got %0d/%0d required 0/0", pkt_cnt, beat_cnt); end
        send_beat(64'h0102_0408_1020_4080, 8'h0F, 1'b1, 2'b01, ok);
        drain(ok);
        tests_run++;
        if (!ok || obs_q.size() != 1) begin tests_failed++; $display("FAIL midrst_count got %0d beats required 1", obs_q.size()); end
        else if (obs_q[0].d !== 64'h8040_2010_0804_0201 || obs_q[0].k !== 8'h0F) begin
            tests_failed++; $display("FAIL midrst_new_mode got %h/%h required 8040201008040201/0f", obs_q[0].d, obs_q[0].k);
        end
    endtask

    task automatic test_stat_clr();
        bit acc, ok;
        clear_queues();
        send_beat(64'hCAFE_F00D_1234_5678, 8'hFF, 1'b0, 2'b01, ok);
        send_beat(64'h0BAD_C0DE_8765_4321, 8'h81, 1'b1, 2'b00, ok);
        m_ready = 1'b1;
        for (int n = 0; n < 20 && inflight.size() != 0; n++) begin
            stat_clr = m_valid && m_last;
            tick(acc);
        end
        stat_clr = 1'b0;
        tests_run++; if (pkt_cnt !== 32'h0 || beat_cnt !== 32'h0) begin tests_failed++; $display("FAIL clr_counters got %0d/%0d required 0/0", pkt_cnt, beat_cnt); end
        tests_run++; if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin tests_failed++; $display("FAIL clr_data got %0d beats required 2 matching model", obs_q.size()); end
    endtask

    task automatic test_random();
        bit acc, ok;
        int errs;
        clear_queues();
        for (int c = 0; c < 400; c++) begin
            s_valid  = ($urandom % 4) != 0;
            s_data   = {$urandom, $urandom};
            s_keep   = 8'($urandom);
            s_last   = ($urandom % 4) == 0;
            s_mode   = 2'($urandom);
            m_ready  = ($urandom % 4) != 0;
            stat_clr = ($urandom % 50) == 0;
            tick(acc);
        end
        stat_clr = 1'b0;
        drain(ok);
        tests_run++;
        if (!ok || obs_q.size() != exp_q.size() || obs_q.size() < 50) begin
            tests_failed++; $display("FAIL rand_count got %0d beats, model %0d", obs_q.size(), exp_q.size());
        end else begin
            errs = 0;
            for (int i = 0; i < obs_q.size(); i++) begin
                if (obs_q[i] !== exp_q[i]) begin
                    if (errs < 5) $display("FAIL rand_beat%0d got %h/%h/%b required %h/%h/%b", i,
                        obs_q[i].d, obs_q[i].k, obs_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
                    errs++;
                end
            end
            tests_run++; if (errs != 0) begin tests_failed++; $display("FAIL rand_beats got %0d mismatching beats required 0", errs); end
        end
        tests_run++; if (beat_cnt !== mdl_beats) begin tests_failed++; $display("FAIL rand_beat_cnt got %0d required %0d", beat_cnt, mdl_beats); end
        tests_run++; if (pkt_cnt !== mdl_pkts)   begin tests_failed++; $display("FAIL rand_pkt_cnt got %0d required %0d", pkt_cnt, mdl_pkts); end
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
        s_mode = 2'b00; m_ready = 1'b1; stat_clr = 1'b0;
        test_reset();
        test_lane_bitrev();
        test_lane_swap();
        test_full_rev();
        test_mode_lock();
        test_backpressure();
        test_reset_mid_packet();
        test_stat_clr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout after %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
